// File: rtl/e_digit_out.sv
// Streams the decimal expansion of a WORDS x 16-bit fixed-point value, one digit per handshake.
// Optional macro E_DIGIT_ASCII_EN selects ASCII digit encoding instead of BCD.
module e_digit_out #(
    parameter int WORDS      = 32,
    parameter int NUM_DIGITS = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] in_data [0:WORDS-1],
    output logic        busy,
    output logic [7:0]  digit,
    output logic        digit_valid,
    input  logic        digit_ready,
    output logic        digit_last,
    output logic        range_err,
    output logic        done
);

    localparam int IDX_W = (WORDS > 2) ? $clog2(WORDS) : 1;
    localparam int CNT_W = 12;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [7:0] encode_digit(input logic [3:0] d);
`ifdef E_DIGIT_ASCII_EN
        return 8'h30 + {4'h0, d};
`else
        return {4'h0, d};
`endif
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [15:0]        frac_r      [0:WORDS-1];
    logic [15:0]        frac_nxt_s  [0:WORDS-1];
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_nxt_s;
    logic [3:0]         carry_r;
    logic [3:0]         carry_nxt_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic [7:0]         digit_r;
    logic [7:0]         digit_nxt_s;
    logic               last_r;
    logic               last_nxt_s;
    logic               range_err_r;
    logic               range_err_nxt_s;
    logic               valid_r;
    logic               busy_r;
    logic               done_r;
    logic               handshake_s;
    logic [19:0]        prod_s;

    // Next-state and datapath decode for the conversion FSM.
    always_comb begin
        state_nxt_s     = state_r;
        frac_nxt_s      = frac_r;
        idx_nxt_s       = idx_r;
        carry_nxt_s     = carry_r;
        count_nxt_s     = count_r;
        digit_nxt_s     = digit_r;
        last_nxt_s      = last_r;
        range_err_nxt_s = range_err_r;
        handshake_s     = valid_r & digit_ready;
        // One word of the fraction times ten, plus the carry from the word below it.
        prod_s          = ({4'h0, frac_r[idx_r]} * 20'd10) + {16'h0, carry_r};

        case (state_r)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < WORDS; i++) begin
                        frac_nxt_s[i] = in_data[i];
                    end
                    count_nxt_s     = {CNT_W{1'b0}};
                    carry_nxt_s     = 4'd0;
                    idx_nxt_s       = IDX_TOP;
                    range_err_nxt_s = (in_data[0] > 16'd9);
                    if (in_data[0] > 16'd9) begin
                        digit_nxt_s = encode_digit(4'd9);
                    end else begin
                        digit_nxt_s = encode_digit(in_data[0][3:0]);
                    end
                    last_nxt_s      = (CNT_LAST == {CNT_W{1'b0}});
                    state_nxt_s     = EMIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EMIT: begin
                if (handshake_s) begin
                    count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_r) begin
                        last_nxt_s  = 1'b0;
                        state_nxt_s = DONE;
                    end else begin
                        idx_nxt_s   = IDX_TOP;
                        carry_nxt_s = 4'd0;
                        state_nxt_s = MUL;
                    end
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            MUL: begin
                frac_nxt_s[idx_r] = prod_s[15:0];
                carry_nxt_s       = prod_s[19:16];
                if (idx_r == IDX_END) begin
                    digit_nxt_s = encode_digit(prod_s[19:16]);
                    last_nxt_s  = (count_r == CNT_LAST);
                    state_nxt_s = EMIT;
                end else begin
                    idx_nxt_s   = idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
                    state_nxt_s = MUL;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            for (int i = 0; i < WORDS; i++) begin
                frac_r[i] <= 16'h0000;
            end
            idx_r       <= {IDX_W{1'b0}};
            carry_r     <= 4'd0;
            count_r     <= {CNT_W{1'b0}};
            digit_r     <= 8'h00;
            last_r      <= 1'b0;
            range_err_r <= 1'b0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            frac_r      <= frac_nxt_s;
            idx_r       <= idx_nxt_s;
            carry_r     <= carry_nxt_s;
            count_r     <= count_nxt_s;
            digit_r     <= digit_nxt_s;
            last_r      <= last_nxt_s;
            range_err_r <= range_err_nxt_s;
            valid_r     <= (state_nxt_s == EMIT);
            busy_r      <= (state_nxt_s != IDLE);
            done_r      <= (state_nxt_s == DONE);
        end
    end

    assign busy        = busy_r;
    assign digit       = digit_r;
    assign digit_valid = valid_r;
    assign digit_last  = last_r;
    assign range_err   = range_err_r;
    assign done        = done_r;

endmodule

// File: tb/tb_e_digit_out.sv
// Scoreboard bench for e_digit_out with WORDS=4, NUM_DIGITS=4.
module tb_e_digit_out;

    localparam int WORDS = 4;
    localparam int ND    = 4;
    localparam int TMO   = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] in_data [0:WORDS-1];
    logic        busy;
    logic [7:0]  digit;
    logic        digit_valid;
    logic        digit_ready;
    logic        digit_last;
    logic        range_err;
    logic        done;

    logic [7:0]  sb_q [$];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    e_digit_out #(.WORDS(WORDS), .NUM_DIGITS(ND)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_data     (in_data),
        .busy        (busy),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit_last  (digit_last),
        .range_err   (range_err),
        .done        (done)
    );

    function automatic logic [7:0] enc(input int d);
`ifdef E_DIGIT_ASCII_EN
        return 8'(8'h30 + d);
`else
        return 8'(d);
`endif
    endfunction

    // Reference: whole 48-bit fraction as one integer, times ten per digit.
    task automatic push_model(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
        logic [63:0] f;
        int d;
        d = (w0 > 16'd9) ? 9 : int'(w0);
        sb_q.push_back(enc(d));
        f = {16'h0000, w1, w2, w3};
        for (int k = 1; k < ND; k++) begin
            f = f * 64'd10;
            d = int'(f[51:48]);
            f = f & 64'h0000_FFFF_FFFF_FFFF;
            sb_q.push_back(enc(d));
        end
    endtask

    task automatic start_run(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
        in_data[0] = w0;
        in_data[1] = w1;
        in_data[2] = w2;
        in_data[3] = w3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drain the scoreboard; optional stall on one digit and start pokes while busy.
    task automatic consume(input string tag, input int stall_idx, input int stall_len,
                           input int poke_idx);
        int n;
        int wc;
        bit tmo;
        logic [7:0] exp_d;
        logic exp_last;
        n = 0;
        tmo = 1'b0;
        digit_ready = 1'b1;
        while (sb_q.size() > 0) begin
            exp_d = sb_q.pop_front();
            exp_last = (sb_q.size() == 0);
            wc = 0;
            while (!digit_valid && wc < TMO) begin
                @(posedge clk); #1;
                wc++;
            end
            checks++;
            if (digit_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s timeout digit%0d got valid=%b exp=1", tag, n, digit_valid);
                sb_q.delete();
                tmo = 1'b1;
                break;
            end
            checks++;
            if (wc != ((n == 0) ? 0 : WORDS - 1)) begin
                failures++;
                $display("FAIL %s latency digit%0d got=%0d exp=%0d", tag, n, wc,
                         (n == 0) ? 0 : WORDS - 1);
            end
            if (n == stall_idx) begin
                digit_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (digit_valid !== 1'b1 || digit !== exp_d || digit_last !== exp_last) begin
                        failures++;
                        $display("FAIL %s stall%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                                 tag, s, digit_valid, digit, digit_last, exp_d, exp_last);
                    end
                end
                digit_ready = 1'b1;
            end
            checks++;
            if (digit !== exp_d) begin
                failures++;
                $display("FAIL %s digit%0d got=%h exp=%h", tag, n, digit, exp_d);
            end
            checks++;
            if (digit_last !== exp_last) begin
                failures++;
                $display("FAIL %s last%0d got=%b exp=%b", tag, n, digit_last, exp_last);
            end
            if (n == poke_idx) begin
                start = 1'b1;
                in_data[0] = 16'h0001;
                in_data[1] = 16'hFFFF;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        if (!tmo) begin
            checks++;
            if (done !== 1'b1 || digit_valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s done_pulse got done=%b v=%b busy=%b exp 1 0 1",
                         tag, done, digit_valid, busy);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL %s done_end got done=%b busy=%b exp 0 0", tag, done, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || digit_valid !== 1'b0 || digit_last !== 1'b0 || done !== 1'b0 ||
            range_err !== 1'b0 || digit !== 8'h00) begin
            failures++;
            $display("FAIL reset got busy=%b v=%b l=%b done=%b err=%b d=%h exp all 0",
                     busy, digit_valid, digit_last, done, range_err, digit);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        sb_q.push_back(enc(3));
        sb_q.push_back(enc(2));
        sb_q.push_back(enc(5));
        sb_q.push_back(enc(0));
        start_run(16'd3, 16'h4000, 16'h0000, 16'h0000);
        consume("basic", -1, 0, -1);
        checks++;
        if (range_err !== 1'b0) begin
            failures++;
            $display("FAIL basic range_err got=%b exp=0", range_err);
        end
    endtask

    task automatic test_backpressure();
        sb_q.push_back(enc(3));
        sb_q.push_back(enc(2));
        sb_q.push_back(enc(5));
        sb_q.push_back(enc(0));
        start_run(16'd3, 16'h4000, 16'h0000, 16'h0000);
        consume("backpressure", 1, 5, -1);
    endtask

    task automatic test_range();
        push_model(16'd12, 16'h8000, 16'h0000, 16'h0000);
        start_run(16'd12, 16'h8000, 16'h0000, 16'h0000);
        checks++;
        if (range_err !== 1'b1) begin
            failures++;
            $display("FAIL range_set got=%b exp=1", range_err);
        end
        consume("range", -1, 0, -1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (range_err !== 1'b1) begin
            failures++;
            $display("FAIL range_sticky got=%b exp=1", range_err);
        end
        push_model(16'd1, 16'h1234, 16'h5678, 16'h9ABC);
        start_run(16'd1, 16'h1234, 16'h5678, 16'h9ABC);
        checks++;
        if (range_err !== 1'b0) begin
            failures++;
            $display("FAIL range_clear got=%b exp=0", range_err);
        end
        consume("range_next", -1, 0, -1);
    endtask

    task automatic test_start_ignored();
        push_model(16'd7, 16'hA5A5, 16'h0F0F, 16'h3C3C);
        start_run(16'd7, 16'hA5A5, 16'h0F0F, 16'h3C3C);
        consume("start_ignored", -1, 0, 1);
        repeat (WORDS + 2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || digit_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored_idle got busy=%b v=%b exp 0 0", busy, digit_valid);
        end
    endtask

    task automatic test_reset_mid();
        push_model(16'd3, 16'h4000, 16'h0000, 16'h0000);
        start_run(16'd3, 16'h4000, 16'h0000, 16'h0000);
        digit_ready = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || digit_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b v=%b done=%b exp 0 0 0", busy, digit_valid, done);
        end
        rst = 1'b0;
        repeat (WORDS + 2) @(posedge clk);
        #1;
        checks++;
        if (digit_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_quiet got v=%b busy=%b exp 0 0", digit_valid, busy);
        end
        push_model(16'd2, 16'hC000, 16'h0001, 16'h8000);
        start_run(16'd2, 16'hC000, 16'h0001, 16'h8000);
        consume("reset_mid_rerun", -1, 0, -1);
    endtask

    task automatic test_encoding();
        logic [7:0] first_exp;
`ifdef E_DIGIT_ASCII_EN
        first_exp = 8'h32;
`else
        first_exp = 8'h02;
`endif
        sb_q.push_back(first_exp);
        sb_q.push_back(enc(0));
        sb_q.push_back(enc(0));
        sb_q.push_back(enc(0));
        start_run(16'd2, 16'h0000, 16'h0000, 16'h0000);
        consume("encoding", -1, 0, -1);
    endtask

    task automatic test_random();
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [15:0] w3;
        for (int r = 0; r < 4; r++) begin
            w0 = 16'($urandom_range(0, 15));
            w1 = 16'($urandom);
            w2 = 16'($urandom);
            w3 = 16'($urandom);
            push_model(w0, w1, w2, w3);
            start_run(w0, w1, w2, w3);
            consume("random", (r == 2) ? 2 : -1, 3, -1);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        digit_ready = 1'b1;
        for (int i = 0; i < WORDS; i++) begin
            in_data[i] = 16'h0000;
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_range();
        test_start_ignored();
        test_reset_mid();
        test_encoding();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
